// File: rtl/cam_pkg.sv
// Shared types, constants and the exposure clamp for the camera frame timing generator.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int HTOTAL_DEF = 136;
  localparam int VTOTAL_DEF = 1027;
  localparam int EXP_MIN    = 3;
  localparam int CNT_W      = 11;

  // Lines 0..2 are downstream overhead, so exposure may never point into them;
  // the upper bound is the last line of the frame.
  function automatic logic [CNT_W-1:0] clamp_exp(input logic [CNT_W-1:0] val,
                                                 input logic [CNT_W-1:0] vmax);
    if (val < CNT_W'(EXP_MIN)) begin
      return CNT_W'(EXP_MIN);
    end else if (val > vmax) begin
      return vmax;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/cam_hvgen.sv
// Sensor frame timing generator: free-running line/pixel counters plus
// run/stop, exposure and correction requests that only take effect on frame
// boundaries, so the readout controller never sees a mid-frame change.
import cam_pkg::*;

module cam_hvgen #(
  parameter int HTOTAL  = HTOTAL_DEF,
  parameter int VTOTAL  = VTOTAL_DEF,
  parameter int EXP_DEF = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] exp_in,
  input  logic             exp_wr,
  input  logic             korr_req,
  output logic             endet,
  output logic [CNT_W-1:0] ah,
  output logic [CNT_W-1:0] av,
  output logic [CNT_W-1:0] iexp,
  output logic             korr,
  output logic             fstart,
  output logic             busy,
  output logic             exp_pend
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HTOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VTOTAL - 1);
  localparam logic [CNT_W-1:0] EXP_RST = CNT_W'(EXP_DEF);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ah_q, ah_d;
  logic [CNT_W-1:0] av_q, av_d;
  logic [CNT_W-1:0] iexp_q, iexp_d;
  logic [CNT_W-1:0] exp_hold_q, exp_hold_d;
  logic             exp_pend_q, exp_pend_d;
  logic             korr_q, korr_d;
  logic             korr_pend_q, korr_pend_d;
  logic             fstart_q, fstart_d;

  logic             frame_end;
  logic             xfer;
  logic [CNT_W-1:0] exp_clamped;

  // Frame end is the last pixel of the last line while streaming; the
  // exposure transfer point is frame end, or any cycle spent idle.
  assign frame_end   = (state_q != IDLE) && (ah_q == H_LAST) && (av_q == V_LAST);
  assign xfer        = frame_end || (state_q == IDLE);
  assign exp_clamped = clamp_exp(exp_in, V_LAST);

  // State and boundary-update registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ah_q        <= '0;
      av_q        <= '0;
      iexp_q      <= EXP_RST;
      exp_hold_q  <= EXP_RST;
      exp_pend_q  <= 1'b0;
      korr_q      <= 1'b0;
      korr_pend_q <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ah_q        <= ah_d;
      av_q        <= av_d;
      iexp_q      <= iexp_d;
      exp_hold_q  <= exp_hold_d;
      exp_pend_q  <= exp_pend_d;
      korr_q      <= korr_d;
      korr_pend_q <= korr_pend_d;
      fstart_q    <= fstart_d;
    end
  end

  // Next state: stop beats a simultaneous start in RUN; start cancels a drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN: begin
        if (start)          state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters restart from zero on entering or leaving streaming, else wrap.
  always_comb begin
    ah_d = ah_q;
    av_d = av_q;
    if ((state_q == IDLE) || (state_d == IDLE)) begin
      ah_d = '0;
      av_d = '0;
    end else if (ah_q == H_LAST) begin
      ah_d = '0;
      av_d = (av_q == V_LAST) ? '0 : av_q + CNT_W'(1);
    end else begin
      ah_d = ah_q + CNT_W'(1);
    end
    fstart_d = (state_d != IDLE) && (ah_d == '0) && (av_d == '0);
  end

  // Exposure: a write on a transfer cycle bypasses the pending register.
  always_comb begin
    iexp_d     = iexp_q;
    exp_hold_d = exp_hold_q;
    exp_pend_d = exp_pend_q;
    if (exp_wr && xfer) begin
      iexp_d     = exp_clamped;
      exp_pend_d = 1'b0;
    end else if (xfer && exp_pend_q) begin
      iexp_d     = exp_hold_q;
      exp_pend_d = 1'b0;
    end else if (exp_wr) begin
      exp_hold_d = exp_clamped;
      exp_pend_d = 1'b1;
    end
  end

  // Correction: a pending request is consumed when a new frame begins; a
  // request arriving on that same cycle waits for the following frame.
  always_comb begin
    korr_d      = korr_q;
    korr_pend_d = korr_pend_q | korr_req;
    if (state_q == IDLE) begin
      if (state_d == RUN) begin
        korr_d      = korr_pend_q;
        korr_pend_d = korr_req;
      end else begin
        korr_d = 1'b0;
      end
    end else if (frame_end) begin
      if (state_d == IDLE) begin
        korr_d = 1'b0;
      end else begin
        korr_d      = korr_pend_q;
        korr_pend_d = korr_req;
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    endet    = (state_q != IDLE);
    busy     = (state_q != IDLE);
    ah       = ah_q;
    av       = av_q;
    iexp     = iexp_q;
    korr     = korr_q;
    fstart   = fstart_q;
    exp_pend = exp_pend_q;
  end

endmodule

// File: tb/tb_cam_hvgen.sv
// Self-checking bench for cam_hvgen: clamp table, directed frame-boundary
// sequences and randomized stimulus against a position-based frame model.
module tb_cam_hvgen;

  localparam int HT    = 136;
  localparam int VT    = 8;
  localparam int FRAME = HT * VT;
  localparam int EXPD  = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] exp_in = '0;
  logic        exp_wr = 1'b0;
  logic        korr_req = 1'b0;
  logic        endet, korr, fstart, busy, exp_pend;
  logic [10:0] ah, av, iexp;

  int n_chk  = 0;
  int n_fail = 0;
  int fcount = 0;

  cam_hvgen #(.HTOTAL(HT), .VTOTAL(VT), .EXP_DEF(EXPD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .exp_in(exp_in), .exp_wr(exp_wr), .korr_req(korr_req),
    .endet(endet), .ah(ah), .av(av), .iexp(iexp), .korr(korr),
    .fstart(fstart), .busy(busy), .exp_pend(exp_pend)
  );

  always #5 clk = ~clk;

  // Reference model: the frame as a single position counter 0..FRAME-1.
  bit m_run, m_drain, m_pend, m_korr, m_kpend;
  int m_pos, m_iexp, m_pexp;

  task automatic m_reset();
    m_run = 0; m_drain = 0; m_pend = 0; m_korr = 0; m_kpend = 0;
    m_pos = 0; m_iexp = EXPD; m_pexp = EXPD;
  endtask

  task automatic m_step(bit st, bit sp, bit ew, int ei, bit kr);
    bit fe, xf;
    int c;
    fe = m_run && (m_pos == FRAME - 1);
    xf = fe || !m_run;
    c  = (ei < 3) ? 3 : ((ei > VT - 1) ? VT - 1 : ei);
    if (ew && xf) begin
      m_iexp = c; m_pend = 0;
    end else if (xf && m_pend) begin
      m_iexp = m_pexp; m_pend = 0;
    end else if (ew) begin
      m_pexp = c; m_pend = 1;
    end
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_drain = 0; m_pos = 0;
        m_korr = m_kpend; m_kpend = kr;
      end else begin
        m_korr = 0; m_kpend = m_kpend | kr;
      end
    end else if (m_drain && !st && fe) begin
      m_run = 0; m_drain = 0; m_pos = 0;
      m_korr = 0; m_kpend = m_kpend | kr;
    end else begin
      m_drain = m_drain ? !st : sp;
      m_pos   = (m_pos + 1) % FRAME;
      if (fe) begin
        m_korr = m_kpend; m_kpend = kr;
      end else begin
        m_kpend = m_kpend | kr;
      end
    end
  endtask

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, step model, compare every output just after the edge.
  task automatic cyc(bit st, bit sp, bit ew, int ei, bit kr);
    longint mf;
    start = st; stop = sp; exp_wr = ew; exp_in = 11'(ei); korr_req = kr;
    @(posedge clk);
    m_step(st, sp, ew, ei, kr);
    #1;
    start = 0; stop = 0; exp_wr = 0; korr_req = 0;
    if (fstart) fcount++;
    mf = {m_run, m_run, m_run && (m_pos == 0), m_korr, m_pend, 11'(m_iexp)};
    chk("pos", {ah, av}, {11'(m_pos % HT), 11'(m_pos / HT)});
    chk("flags", {endet, busy, fstart, korr, exp_pend, iexp}, mf);
  endtask

  task automatic run_to(int target);
    for (int i = 0; i < 3000 && !(endet && (int'(av) * HT + int'(ah) == target)); i++)
      cyc(0, 0, 0, 0, 0);
    chk("run_to", int'(av) * HT + int'(ah), target);
  endtask

  typedef struct {
    int exp_in;
    int iexp_exp;
  } clamp_vec_t;

  clamp_vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 3};    vecs[1] = '{1, 3};    vecs[2] = '{2, 3};
    vecs[3] = '{3, 3};    vecs[4] = '{4, 4};    vecs[5] = '{7, 7};
    vecs[6] = '{8, 7};    vecs[7] = '{2000, 7}; vecs[8] = '{2047, 7};

    m_reset();
    #12;
    // Reset values
    chk("rst_endet", endet, 0);   chk("rst_ah", ah, 0);      chk("rst_av", av, 0);
    chk("rst_iexp", iexp, EXPD);  chk("rst_korr", korr, 0);  chk("rst_fstart", fstart, 0);
    chk("rst_busy", busy, 0);     chk("rst_pend", exp_pend, 0);
    rst_n = 1;
    cyc(0, 1, 0, 0, 0);
    chk("stop_idle_ignored", busy, 0);

    // Clamp table: an idle write lands in iexp on the next cycle
    foreach (vecs[i]) begin
      cyc(0, 0, 1, vecs[i].exp_in, 0);
      chk("clamp_iexp", iexp, vecs[i].iexp_exp);
      chk("clamp_pend", exp_pend, 0);
    end

    // Start and first line wrap
    cyc(1, 0, 0, 0, 0);
    chk("start_endet", endet, 1); chk("start_ah", ah, 0); chk("start_av", av, 0);
    chk("start_fstart", fstart, 1); chk("start_busy", busy, 1);
    run_to(HT - 1);
    chk("line_end_ah", ah, 135);
    cyc(0, 0, 0, 0, 0);
    chk("wrap_ah", ah, 0); chk("wrap_av", av, 1); chk("wrap_fstart", fstart, 0);

    // Exposure pending mid-frame, applied at frame start
    cyc(0, 0, 1, 1, 0);
    chk("exp_pend_set", exp_pend, 1); chk("exp_hold_iexp", iexp, 7);
    run_to(FRAME - 1);
    chk("exp_before_fe", iexp, 7);
    cyc(0, 0, 0, 0, 0);
    chk("exp_applied", iexp, 3); chk("exp_pend_clr", exp_pend, 0);
    cyc(0, 0, 1, 2000, 0);
    run_to(FRAME - 1);
    cyc(0, 0, 0, 0, 0);
    chk("exp_max", iexp, 7);
    // Write on the frame-end cycle overrides an older pending value
    run_to(HT * 3);
    cyc(0, 0, 1, 6, 0);
    run_to(FRAME - 1);
    cyc(0, 0, 1, 5, 0);
    chk("exp_fe_write", iexp, 5); chk("exp_fe_pend", exp_pend, 0);

    // Correction frame
    run_to(2 * HT);
    cyc(0, 0, 0, 0, 1);
    chk("korr_not_yet", korr, 0);
    run_to(FRAME - 1);
    cyc(0, 0, 0, 0, 0);
    chk("korr_on", korr, 1);
    run_to(FRAME - 1);
    chk("korr_whole_frame", korr, 1);
    cyc(0, 0, 0, 0, 1);
    chk("korr_fe_req_off", korr, 0);
    run_to(FRAME - 1);
    cyc(0, 0, 0, 0, 0);
    chk("korr_fe_req_on", korr, 1);
    run_to(FRAME - 1);
    cyc(0, 0, 0, 0, 0);
    chk("korr_off_again", korr, 0);

    // Stop at av=3, drain to frame end, one fstart per frame
    run_to(FRAME - 1);
    fcount = 0;
    cyc(0, 0, 0, 0, 0);
    run_to(FRAME - 1);
    cyc(0, 0, 0, 0, 0);
    run_to(3 * HT);
    cyc(0, 1, 0, 0, 0);
    chk("drain_busy", busy, 1);
    run_to(FRAME - 1);
    chk("drain_last_ah", ah, 135); chk("drain_last_av", av, 7); chk("drain_endet", endet, 1);
    cyc(0, 0, 0, 0, 0);
    chk("stopped_endet", endet, 0); chk("stopped_ah", ah, 0);
    chk("stopped_av", av, 0); chk("stopped_busy", busy, 0);
    repeat (20) cyc(0, 0, 0, 0, 0);
    chk("fstart_count", fcount, 2);

    // start+stop together in RUN drains; start in DRAIN resumes
    cyc(1, 0, 0, 0, 0);
    run_to(50);
    cyc(1, 1, 0, 0, 0);
    run_to(1000);
    cyc(1, 0, 0, 0, 0);
    run_to(FRAME - 1);
    cyc(0, 0, 0, 0, 0);
    chk("resume_endet", endet, 1); chk("resume_fstart", fstart, 1);
    repeat (10) cyc(0, 0, 0, 0, 0);

    // Randomized stimulus against the model
    for (int i = 0; i < 9000; i++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 799) == 0,
          $urandom_range(0, 99) == 0, int'($urandom_range(0, 2047)),
          $urandom_range(0, 299) == 0);
    end

    // Asynchronous reset mid-frame
    if (!m_run) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (300) cyc(0, 0, 1, 5, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_endet", endet, 0);   chk("arst_ah", ah, 0);      chk("arst_av", av, 0);
    chk("arst_iexp", iexp, EXPD);  chk("arst_korr", korr, 0);  chk("arst_fstart", fstart, 0);
    chk("arst_busy", busy, 0);     chk("arst_pend", exp_pend, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("arst_korr_pend_cleared", korr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
